// File: rtl/axil_if.sv
// AXI4-Lite bus bundle. The master modport is the initiator side and the slave modport is the responder side.
interface axil_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [addr_width-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [data_width-1:0]   wdata;
  logic [data_width/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [addr_width-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [data_width-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator that turns one command into one read or write transaction.
// Handshake rule: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module axil_master #(
  parameter int axil_addr_width = 32,
  parameter int axil_data_width = 32,
  parameter int err_count_width = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [axil_addr_width-1:0]   cmd_addr,
  input  logic [axil_data_width-1:0]   cmd_wdata,
  input  logic [axil_data_width/8-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [axil_data_width-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic [err_count_width-1:0]   err_count,
  output logic [2:0]                   dbg_state,
  axil_if.master                       m_axi
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_B   = 3'd2,
    RD_AR  = 3'd3,
    RD_R   = 3'd4,
    RSP    = 3'd5
  } state_t;

  localparam logic [err_count_width-1:0] err_one = 1;

  state_t state;
  logic   aw_fire;
  logic   w_fire;

  // Only SLVERR/DECERR count as errors; EXOKAY is a success.
  function automatic logic [err_count_width-1:0] bump_err(
    input logic [err_count_width-1:0] cnt,
    input logic [1:0]                 resp
  );
    if (resp[1] && (cnt != '1)) return cnt + err_one;
    return cnt;
  endfunction

  assign cmd_ready    = (state == IDLE) && !rst;
  assign aw_fire      = m_axi.awvalid && m_axi.awready;
  assign w_fire       = m_axi.wvalid && m_axi.wready;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.bready  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      err_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              m_axi.awaddr  <= cmd_addr;
              m_axi.wdata   <= cmd_wdata;
              m_axi.wstrb   <= cmd_wstrb;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi.araddr  <= cmd_addr;
              m_axi.arvalid <= 1'b1;
              state         <= RD_AR;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently; move on once neither is still pending.
          if (aw_fire) m_axi.awvalid <= 1'b0;
          if (w_fire)  m_axi.wvalid  <= 1'b0;
          if ((aw_fire || !m_axi.awvalid) && (w_fire || !m_axi.wvalid)) begin
            m_axi.bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi.bvalid && m_axi.bready) begin
            m_axi.bready <= 1'b0;
            rsp_resp     <= m_axi.bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            err_count    <= bump_err(err_count, m_axi.bresp);
            state        <= RSP;
          end
        end
        RD_AR: begin
          if (m_axi.arvalid && m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi.rvalid && m_axi.rready) begin
            m_axi.rready <= 1'b0;
            rsp_resp     <= m_axi.rresp;
            rsp_rdata    <= m_axi.rdata;
            rsp_valid    <= 1'b1;
            err_count    <= bump_err(err_count, m_axi.rresp);
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: table of transactions against a latency-programmable responder,
// plus hand sequences for back-pressure, response stall, reset in flight and counter saturation.
module tb_axil_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ECW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [ECW-1:0] err_count;
  logic [2:0]    dbg_state;

  axil_if #(.addr_width(AW), .data_width(DW)) m_if ();

  axil_master #(.axil_addr_width(AW), .axil_data_width(DW), .err_count_width(ECW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err_count(err_count), .dbg_state(dbg_state),
    .m_axi(m_if)
  );

  // Narrow-counter instance: reaching all-ones takes only a few error responses.
  logic          c2_valid, c2_ready, rsp2_valid;
  logic [DW-1:0] rsp2_rdata;
  logic [1:0]    rsp2_resp, err2;
  logic [2:0]    dbg2;
  logic [AW-1:0] c2_addr;
  logic [DW-1:0] c2_wdata;
  logic [DW/8-1:0] c2_wstrb;
  logic          c2_write, rsp2_ready;

  axil_if #(.addr_width(AW), .data_width(DW)) m2_if ();

  axil_master #(.axil_addr_width(AW), .axil_data_width(DW), .err_count_width(2)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_write(c2_write),
    .cmd_addr(c2_addr), .cmd_wdata(c2_wdata), .cmd_wstrb(c2_wstrb),
    .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready), .rsp_rdata(rsp2_rdata),
    .rsp_resp(rsp2_resp), .err_count(err2), .dbg_state(dbg2),
    .m_axi(m2_if)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responder model ----------------
  int aw_lat, w_lat, ar_lat, b_lat, r_lat;
  logic [1:0]    s_resp;
  logic [DW-1:0] s_rdata;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_wstrb;
  int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit  aw_got, w_got, ar_got, b_pend, r_pend, b_f, r_f, s_rst;

  always begin
    @(negedge clk);
    s_rst = rst;
    if (!rst && r_pend) check("rready_wait", 64'(m_if.rready), 64'd1);
    b_f = m_if.bvalid && m_if.bready;
    r_f = m_if.rvalid && m_if.rready;
    if (m_if.awvalid && m_if.awready) begin s_awaddr = m_if.awaddr; aw_got = 1'b1; end
    if (m_if.wvalid && m_if.wready) begin s_wdata = m_if.wdata; s_wstrb = m_if.wstrb; w_got = 1'b1; end
    if (m_if.arvalid && m_if.arready) begin s_araddr = m_if.araddr; ar_got = 1'b1; end
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
      m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    end else begin
      if (m_if.awvalid) begin m_if.awready = (aw_cnt >= aw_lat); aw_cnt++; end
      else begin m_if.awready = 1'b0; aw_cnt = 0; end
      if (m_if.wvalid) begin m_if.wready = (w_cnt >= w_lat); w_cnt++; end
      else begin m_if.wready = 1'b0; w_cnt = 0; end
      if (m_if.arvalid) begin m_if.arready = (ar_cnt >= ar_lat); ar_cnt++; end
      else begin m_if.arready = 1'b0; ar_cnt = 0; end
      if (b_f) begin m_if.bvalid = 1'b0; b_pend = 1'b0; end
      if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = b_lat; end
      if (b_pend && !m_if.bvalid) begin
        if (b_cnt == 0) begin m_if.bvalid = 1'b1; m_if.bresp = s_resp; end
        else b_cnt--;
      end
      if (r_f) begin m_if.rvalid = 1'b0; r_pend = 1'b0; end
      if (ar_got) begin ar_got = 1'b0; r_pend = 1'b1; r_cnt = r_lat; end
      if (r_pend && !m_if.rvalid) begin
        if (r_cnt == 0) begin m_if.rvalid = 1'b1; m_if.rdata = s_rdata; m_if.rresp = s_resp; end
        else r_cnt--;
      end
    end
  end

  // Second responder: always-ready reads that return SLVERR one cycle later.
  bit r2_f, r2_done, r2_rst;
  always begin
    @(negedge clk);
    r2_rst  = rst;
    r2_f    = m2_if.arvalid && m2_if.arready;
    r2_done = m2_if.rvalid && m2_if.rready;
    @(posedge clk);
    #1;
    if (r2_rst) m2_if.rvalid = 1'b0;
    else if (r2_f) m2_if.rvalid = 1'b1;
    else if (r2_done) m2_if.rvalid = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!got) check("cmd_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Called just after the edge that starts cycle c0; returns at the negedge where rsp_valid is seen.
  task automatic wait_rsp(input int c0, output int cyc);
    cyc = c0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) return;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rsp_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic            write;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    int              aw_lat;
    int              w_lat;
    int              ar_lat;
    int              x_lat;
    logic [1:0]      resp;
    logic [DW-1:0]   rdata;
    logic [DW-1:0]   exp_rdata;
    logic [1:0]      exp_resp;
    logic [ECW-1:0]  exp_err;
    int              exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    int cyc;
    aw_lat = v.aw_lat; w_lat = v.w_lat; ar_lat = v.ar_lat;
    b_lat = v.x_lat; r_lat = v.x_lat;
    s_resp = v.resp; s_rdata = v.rdata;
    rsp_ready = 1'b1;
    send_cmd(v.write, v.addr, v.wdata, v.wstrb);
    wait_rsp(1, cyc);
    check("vec_latency", 64'(cyc), 64'(v.exp_lat));
    check("vec_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    check("vec_resp", 64'(rsp_resp), 64'(v.exp_resp));
    check("vec_err_count", 64'(err_count), 64'(v.exp_err));
    @(posedge clk);
    #1;
    if (v.write) begin
      check("vec_awaddr", 64'(s_awaddr), 64'(v.addr));
      check("vec_wdata", 64'(s_wdata), 64'(v.wdata));
      check("vec_wstrb", 64'(s_wstrb), 64'(v.wstrb));
    end else begin
      check("vec_araddr", 64'(s_araddr), 64'(v.addr));
    end
    @(negedge clk);
    check("vec_cmd_ready_after", 64'(cmd_ready), 64'd1);
    check("vec_rsp_valid_after", 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int n2;

    // Expected latency: write 3+max(aw,w)+b, read 3+ar+r cycles from accept to rsp_valid.
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 16'd0, 3};
    tbl[1] = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 5, 2'b00, 32'h12345678, 32'h12345678, 2'b00, 16'd0, 8};
    tbl[2] = '{1'b1, 32'h24, 32'hA5A5A5A5, 4'h3, 2, 0, 0, 1, 2'b01, 32'h0,        32'h0,        2'b01, 16'd0, 6};
    tbl[3] = '{1'b1, 32'h30, 32'h01020304, 4'hC, 0, 3, 0, 0, 2'b10, 32'h0,        32'h0,        2'b10, 16'd1, 6};
    tbl[4] = '{1'b0, 32'h40, 32'h0,        4'h0, 0, 0, 2, 0, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D, 2'b11, 16'd2, 5};
    tbl[5] = '{1'b0, 32'h44, 32'h0,        4'h0, 0, 0, 0, 0, 2'b01, 32'h00000001, 32'h00000001, 2'b01, 16'd2, 3};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00; m_if.rvalid = 1'b0;
    m_if.rdata = '0; m_if.rresp = 2'b00;
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0; s_resp = 2'b00; s_rdata = '0;
    c2_valid = 1'b0; c2_write = 1'b0; c2_addr = 32'h80; c2_wdata = '0; c2_wstrb = '0;
    rsp2_ready = 1'b1;
    m2_if.awready = 1'b0; m2_if.wready = 1'b0; m2_if.arready = 1'b1;
    m2_if.bvalid = 1'b0; m2_if.bresp = 2'b00; m2_if.rvalid = 1'b0;
    m2_if.rdata = '0; m2_if.rresp = 2'b10;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid}), 64'd0);
    check("reset_readies", 64'({m_if.bready, m_if.rready}), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_payload", 64'({rsp_rdata, rsp_resp}), 64'd0);
    check("reset_err_count", 64'(err_count), 64'd0);
    check("reset_bus_payload", 64'({m_if.awaddr, m_if.wstrb}), 64'd0);
    check("reset_prot", 64'({m_if.awprot, m_if.arprot}), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // W back-pressure: awready immediately, wready only in cycle 5.
    aw_lat = 0; w_lat = 4; b_lat = 0; s_resp = 2'b00; rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("bp_awvalid", 64'(m_if.awvalid), 64'(c == 1));
      check("bp_wvalid", 64'(m_if.wvalid), 64'(c <= 5));
      if (c <= 5) check("bp_wdata_stable", 64'(m_if.wdata), 64'h00000000DEADBEEF);
      check("bp_bready", 64'(m_if.bready), 64'(c == 6));
      @(posedge clk);
      #1;
    end
    wait_rsp(7, cyc);
    check("bp_rsp_cycle", 64'(cyc), 64'd7);
    check("bp_rsp_resp", 64'(rsp_resp), 64'd0);
    @(posedge clk);
    #1;

    // Response stall: rsp_ready low for 10 cycles with a competing command present.
    aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0; s_resp = 2'b00; s_rdata = 32'h0BADF00D;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h50, 32'h0, 4'h0);
    wait_rsp(1, cyc);
    check("hold_rsp_cycle", 64'(cyc), 64'd3);
    for (int i = 0; i < 10; i++) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'h000000000BADF00D);
      check("hold_rsp_resp", 64'(rsp_resp), 64'd0);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold_no_axi_valid", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid}), 64'd0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h99;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_release_cmd_ready", 64'(cmd_ready), 64'd1);
    check("hold_release_rsp_valid", 64'(rsp_valid), 64'd0);

    // Reset while waiting in RD_R.
    ar_lat = 0; r_lat = 20;
    send_cmd(1'b0, 32'h60, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pre_rready", 64'(m_if.rready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid}), 64'd0);
    check("rst_readies", 64'({m_if.bready, m_if.rready}), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_err_count", 64'(err_count), 64'd0);
    run_vec(tbl[0]);

    // Saturation on the 2-bit counter: every read returns SLVERR.
    n2 = 0;
    @(posedge clk);
    #1;
    c2_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp2_valid) begin
        n2++;
        check("sat_resp", 64'(rsp2_resp), 64'd2);
        check("sat_err_count", 64'(err2), 64'((n2 > 3) ? 3 : n2));
      end
    end
    c2_valid = 1'b0;
    check("sat_enough_errors", 64'(n2 >= 8), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
